// File: rtl/jt12_kon_array_if.sv
// Key-on write port and slot-serial read port between the register
// interface/sequencer (master) and the key-on array (slave).
interface jt12_kon_array_if;
  // up_keyon is a one-cycle (clk_en-qualified) strobe carrying keyon_ch/keyon_op;
  // keyon_busy stays high until the pending write is applied, and a new strobe
  // while busy replaces the pending data. No back-pressure: writes are never stalled.
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic       keyon_busy;
  logic [1:0] next_op;
  logic [2:0] next_ch;
  logic       keyon_I;
  logic       kon_edge;
  logic       koff_edge;

  modport master (
    output keyon_op, keyon_ch, up_keyon, next_op, next_ch,
    input  keyon_busy, keyon_I, kon_edge, koff_edge
  );

  modport slave (
    input  keyon_op, keyon_ch, up_keyon, next_op, next_ch,
    output keyon_busy, keyon_I, kon_edge, koff_edge
  );
endinterface

// File: rtl/jt12_kon_array.sv
// Key-on state array with slot-aligned atomic channel writes and edge detection.
// Optional CSM keying on timer A overflow is enabled by defining JT12_KON_CSM_EN.
module jt12_kon_array #(
  parameter int NUM_CH = 6,
  parameter int CSM_CH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             csm,
  input  logic             overflow_A,
  jt12_kon_array_if.slave  bus,
  output logic             dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] pend_ch;
  logic [3:0] pend_op;
  logic       load_pend;
  logic       do_apply;
  logic       write_ok;
  logic [1:0] op_bit;
  logic [3:0] kon  [NUM_CH];
  logic [3:0] prev [NUM_CH];
  logic       arr_bit;
  logic       prev_bit;
  logic       csm_bit;
  logic       eff;

  assign write_ok       = bus.up_keyon && ({1'b0, bus.keyon_ch} < 4'(NUM_CH));
  // Slot order is S1,S3,S2,S4: swapping the two bits gives the mask bit index.
  assign op_bit         = {bus.next_op[0], bus.next_op[1]};
  assign bus.keyon_busy = (state == ST_PEND);
  assign dbg_state      = state;

  always_comb begin
    arr_bit  = 1'b0;
    prev_bit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.next_ch == 3'(c)) begin
        arr_bit  = kon[c][op_bit];
        prev_bit = prev[c][op_bit];
      end
    end
  end

`ifdef JT12_KON_CSM_EN
  logic       csm_hold;
  logic [1:0] csm_op;
  logic [2:0] csm_ch;

  assign csm_bit = csm & csm_hold & (bus.next_ch == 3'(CSM_CH));

  // Hold lasts until the recorded slot comes round again: exactly one rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      csm_hold <= 1'b0;
      csm_op   <= 2'd0;
      csm_ch   <= 3'd0;
    end else if (clk_en) begin
      if (overflow_A) begin
        csm_hold <= 1'b1;
        csm_op   <= bus.next_op;
        csm_ch   <= bus.next_ch;
      end else if (csm_hold && bus.next_op == csm_op && bus.next_ch == csm_ch) begin
        csm_hold <= 1'b0;
      end
    end
  end
`else
  localparam int unused_csm_ch = CSM_CH;
  logic unused_csm;
  assign unused_csm = csm ^ overflow_A;
  assign csm_bit    = 1'b0;
`endif

  assign eff = arr_bit | csm_bit;

  always_comb begin
    state_nxt = state;
    load_pend = 1'b0;
    do_apply  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (write_ok) begin
          load_pend = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (bus.next_ch == pend_ch && bus.next_op == 2'd3) begin
          do_apply  = 1'b1;
          state_nxt = ST_IDLE;
        end
        // A write landing on the apply edge becomes the next pending write.
        if (write_ok) begin
          load_pend = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_ch       <= 3'd0;
      pend_op       <= 4'd0;
      bus.keyon_I   <= 1'b0;
      bus.kon_edge  <= 1'b0;
      bus.koff_edge <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        kon[c]  <= 4'd0;
        prev[c] <= 4'd0;
      end
    end else if (clk_en) begin
      if (load_pend) begin
        pend_ch <= bus.keyon_ch;
        pend_op <= bus.keyon_op;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (do_apply && pend_ch == 3'(c)) kon[c] <= pend_op;
        if (bus.next_ch == 3'(c)) prev[c][op_bit] <= eff;
      end
      bus.keyon_I   <= eff;
      bus.kon_edge  <= eff & ~prev_bit;
      bus.koff_edge <= ~eff & prev_bit;
    end
  end

endmodule

// File: tb/tb_jt12_kon_array.sv
// Directed self-checking bench for jt12_kon_array (NUM_CH=6, CSM_CH=2).
// Slot rotation is operator-major: slot s -> next_op = s/6, next_ch = s%6.
module tb_jt12_kon_array;

  localparam int NCH = 6;
  localparam int NSLOT = 4 * NCH;

  logic clk;
  logic rst;
  logic clk_en;
  logic csm;
  logic overflow_A;
  logic dbg_state;
  int   n_vec;
  int   n_err;
  logic [2:0] exp_q[$];

  jt12_kon_array_if bus ();

  jt12_kon_array #(.NUM_CH(NCH), .CSM_CH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .csm        (csm),
    .overflow_A (overflow_A),
    .bus        (bus),
    .dbg_state  (dbg_state)
  );

  wire [2:0] obs = {bus.koff_edge, bus.kon_edge, bus.keyon_I};

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- driver ----
  task automatic drive(input int op, input int ch, input logic wr,
                       input logic [2:0] wch, input logic [3:0] wop);
    bus.next_op  = 2'(op);
    bus.next_ch  = 3'(ch);
    bus.up_keyon = wr;
    bus.keyon_ch = wch;
    bus.keyon_op = wop;
    @(posedge clk);
    #1;
    bus.up_keyon = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    drive(0, 0, 1'b0, 3'd0, 4'd0);
    drive(0, 0, 1'b0, 3'd0, 4'd0);
    rst = 1'b0;
    clk_en = 1'b1;
    n_vec++;
    if ({dbg_state, bus.keyon_busy, obs} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_state: got state=%b busy=%b out=%b, want 0 0 000",
               dbg_state, bus.keyon_busy, obs);
    end
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        drive(s / NCH, s % NCH, 1'b0, 3'd0, 4'd0);
        n_vec++;
        if ({bus.keyon_busy, obs} !== 4'b0) begin
          n_err++;
          $display("FAIL idle_rot r%0d s%0d: got busy=%b out=%b, want 0 000",
                   r, s, bus.keyon_busy, obs);
        end
      end
    end
  endtask

  task automatic test_csm();
    logic [2:0] e;
`ifdef JT12_KON_CSM_EN
    for (int pass = 0; pass < 2; pass++) begin
      csm = (pass == 0);
      exp_q.delete();
      for (int r = 0; r < 3; r++) begin
        for (int s = 0; s < NSLOT; s++) begin
          e = 3'b000;
          if (pass == 0 && s % NCH == 2) begin
            if (r == 0 && s > 6) e = 3'b011;
            if (r == 1) e = (s < 6) ? 3'b011 : 3'b100;
            if (r == 2 && s < 6) e = 3'b100;
          end
          exp_q.push_back(e);
        end
      end
`else
    for (int pass = 0; pass < 2; pass++) begin
      csm = (pass == 0);
      exp_q.delete();
      for (int k = 0; k < 3 * NSLOT; k++) exp_q.push_back(3'b000);
`endif
      for (int r = 0; r < 3; r++) begin
        for (int s = 0; s < NSLOT; s++) begin
          overflow_A = (r == 0 && s == 6);
          drive(s / NCH, s % NCH, 1'b0, 3'd0, 4'd0);
          overflow_A = 1'b0;
          e = exp_q.pop_front();
          n_vec++;
          if (obs !== e) begin
            n_err++;
            $display("FAIL csm p%0d r%0d s%0d: got out=%b, want %b", pass, r, s, obs, e);
          end
        end
      end
    end
    csm = 1'b0;
  endtask

  task automatic test_keyon();
    logic [2:0] e;
    logic eb;
    exp_q.delete();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NSLOT; s++)
        exp_q.push_back((s % NCH != 1) ? 3'b000 : (r == 1) ? 3'b011 : (r == 2) ? 3'b001 : 3'b000);
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        drive(s / NCH, s % NCH, (r == 0 && s == 0), 3'd1, 4'b1111);
        e  = exp_q.pop_front();
        eb = (r == 0 && s < 19);
        n_vec++;
        if ({bus.keyon_busy, obs} !== {eb, e}) begin
          n_err++;
          $display("FAIL keyon r%0d s%0d: got busy=%b out=%b, want busy=%b out=%b",
                   r, s, bus.keyon_busy, obs, eb, e);
        end
      end
    end
  endtask

  task automatic test_koff();
    logic [2:0] e;
    logic eb;
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        e = 3'b000;
        if (s % NCH == 1) begin
          if (r == 0 || s / NCH < 2) e = 3'b001;
          else if (r == 1) e = 3'b100;
        end
        exp_q.push_back(e);
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        drive(s / NCH, s % NCH, (r == 0 && s == 0), 3'd1, 4'b0101);
        e  = exp_q.pop_front();
        eb = (r == 0 && s < 19);
        n_vec++;
        if ({bus.keyon_busy, obs} !== {eb, e}) begin
          n_err++;
          $display("FAIL koff r%0d s%0d: got busy=%b out=%b, want busy=%b out=%b",
                   r, s, bus.keyon_busy, obs, eb, e);
        end
      end
    end
  endtask

  task automatic test_last_write();
    logic [2:0] e;
    logic eb;
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        e = 3'b000;
        if (s % NCH == 1 && s / NCH < 2) e = 3'b001;
        if (s == 22 && r == 1) e = 3'b011;
        if (s == 22 && r == 2) e = 3'b001;
        exp_q.push_back(e);
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        drive(s / NCH, s % NCH, (r == 0 && s < 2), 3'd4, (s == 0) ? 4'b0001 : 4'b1000);
        e  = exp_q.pop_front();
        eb = (r == 0 && s < 22);
        n_vec++;
        if ({bus.keyon_busy, obs} !== {eb, e}) begin
          n_err++;
          $display("FAIL last_write r%0d s%0d: got busy=%b out=%b, want busy=%b out=%b",
                   r, s, bus.keyon_busy, obs, eb, e);
        end
      end
    end
  endtask

  task automatic test_bad_ch();
    logic [2:0] exp_out [4];
    int slot_ch [4];
    exp_out = '{3'b000, 3'b000, 3'b000, 3'b001};
    slot_ch = '{0, 7, 6, 1};
    for (int k = 0; k < 4; k++) begin
      drive(0, slot_ch[k], (k < 3), 3'(6 + (k & 1)), 4'b1111);
      n_vec++;
      if ({bus.keyon_busy, obs} !== {1'b0, exp_out[k]}) begin
        n_err++;
        $display("FAIL bad_ch k%0d: got busy=%b out=%b, want busy=0 out=%b",
                 k, bus.keyon_busy, obs, exp_out[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    logic eb;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        e = 3'b000;
        if (s % NCH == 1 && s / NCH < 2) e = 3'b001;
        if (s == 22) e = 3'b001;
        if (r == 1 && (s == 0 || s == 15)) e = 3'b011;
        exp_q.push_back(e);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        drive(s / NCH, s % NCH, (r == 0 && (s == 0 || s == 18)),
              (s == 0) ? 3'd0 : 3'd3, (s == 0) ? 4'b0001 : 4'b0010);
        e  = exp_q.pop_front();
        eb = (r == 0 && s < 21);
        n_vec++;
        if ({bus.keyon_busy, obs} !== {eb, e}) begin
          n_err++;
          $display("FAIL back_to_back r%0d s%0d: got busy=%b out=%b, want busy=%b out=%b",
                   r, s, bus.keyon_busy, obs, eb, e);
        end
      end
    end
  endtask

  task automatic test_clk_en_reset();
    drive(0, 0, 1'b1, 3'd5, 4'b1111);
    n_vec++;
    if ({bus.keyon_busy, obs} !== 4'b1001) begin
      n_err++;
      $display("FAIL cer_write: got busy=%b out=%b, want busy=1 out=001", bus.keyon_busy, obs);
    end
    clk_en = 1'b0;
    drive(2, 0, 1'b1, 3'd2, 4'b1111);
    n_vec++;
    if ({bus.keyon_busy, obs} !== 4'b1001) begin
      n_err++;
      $display("FAIL cer_hold: got busy=%b out=%b, want busy=1 out=001", bus.keyon_busy, obs);
    end
    rst = 1'b1;
    drive(2, 0, 1'b0, 3'd0, 4'd0);
    n_vec++;
    if ({bus.keyon_busy, obs} !== 4'b0000) begin
      n_err++;
      $display("FAIL cer_reset: got busy=%b out=%b, want busy=0 out=000", bus.keyon_busy, obs);
    end
    rst = 1'b0;
    clk_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NSLOT; s++) begin
        drive(s / NCH, s % NCH, 1'b0, 3'd0, 4'd0);
        n_vec++;
        if ({bus.keyon_busy, obs} !== 4'b0) begin
          n_err++;
          $display("FAIL cer_rot r%0d s%0d: got busy=%b out=%b, want 0 000",
                   r, s, bus.keyon_busy, obs);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    clk_en = 1'b1;
    csm = 1'b0;
    overflow_A = 1'b0;
    bus.next_op = 2'd0;
    bus.next_ch = 3'd0;
    bus.up_keyon = 1'b0;
    bus.keyon_ch = 3'd0;
    bus.keyon_op = 4'd0;
    test_reset();
    test_csm();
    test_keyon();
    test_koff();
    test_last_write();
    test_bad_ch();
    test_back_to_back();
    test_clk_en_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
